// File: rtl/axi_frame_reader.sv
// AXI4 read master fetching one 0x00RRGGBB frame into an AXI4-Stream video stream.
// Single outstanding burst, gated by pixel FIFO space.
module axi_frame_reader #(
  parameter logic [31:0] C_M_AXI_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arlock,
  output logic [3:0]  m_axi_arcache,
  output logic [2:0]  m_axi_arprot,
  output logic [3:0]  m_axi_arqos,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        frame_start,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        frame_error
);

  localparam int NBURST = FRAME_WIDTH * FRAME_HEIGHT / BURST_LEN;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] SPACE_MAX = (AW+1)'(FIFO_DEPTH - BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t r_state, w_state_nxt;

  logic        r_start_d;
  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic [31:0] r_burst_idx;
  logic        r_out;
  logic [7:0]  r_beat;
  logic [15:0] r_x, r_y;
  logic        r_done, r_err;

  logic [23:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  logic w_start, w_ar_hs, w_r_hs, w_s_hs, w_tvalid;
  logic w_last_px, w_frame_end, w_last_burst, w_ar_go;
  logic w_beat_last, w_unused;

  assign w_start      = frame_start & ~r_start_d;
  assign w_ar_hs      = r_arvalid & m_axi_arready;
  assign w_r_hs       = m_axi_rvalid & r_out;
  assign w_tvalid     = (r_count != '0);
  assign w_s_hs       = w_tvalid & m_axis_tready;
  assign w_beat_last  = (r_beat == 8'(BURST_LEN - 1));
  assign w_last_burst = (r_burst_idx == 32'(NBURST - 1));
  assign w_last_px    = (r_x == 16'(FRAME_WIDTH - 1)) &&
                        (r_y == 16'(FRAME_HEIGHT - 1));
  assign w_frame_end  = w_s_hs & w_last_px & (r_state != S_IDLE);
  assign w_ar_go      = (r_state == S_FETCH) & ~r_out & ~r_arvalid &
                        (r_count <= SPACE_MAX);
  assign w_unused     = ^m_axi_rdata[31:24];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_FETCH;
      S_FETCH: if (w_ar_hs && w_last_burst) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_frame_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state   <= S_IDLE;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= frame_start;
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_burst_idx <= '0;
      r_out       <= 1'b0;
      r_beat      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (r_state == S_IDLE && w_start) begin
        r_err       <= 1'b0;
        r_burst_idx <= '0;
        r_x         <= '0;
        r_y         <= '0;
      end
      if (w_ar_go) begin
        r_arvalid <= 1'b1;
        r_araddr  <= C_M_AXI_TARGET_SLAVE_BASE_ADDR +
                     r_burst_idx * 32'(BURST_LEN * 4);
      end else if (w_ar_hs) begin
        r_arvalid   <= 1'b0;
        r_out       <= 1'b1;
        r_beat      <= '0;
        r_burst_idx <= r_burst_idx + 32'd1;
      end
      // the beat counter, not rlast, closes the burst
      if (w_r_hs) begin
        if (m_axi_rresp != 2'b00 || m_axi_rlast != w_beat_last)
          r_err <= 1'b1;
        if (w_beat_last) begin
          r_out  <= 1'b0;
          r_beat <= '0;
        end else begin
          r_beat <= r_beat + 8'd1;
        end
      end
      if (w_s_hs) begin
        if (r_x == 16'(FRAME_WIDTH - 1)) begin
          r_x <= '0;
          r_y <= (r_y == 16'(FRAME_HEIGHT - 1)) ? '0 : r_y + 16'd1;
        end else begin
          r_x <= r_x + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_r_hs) r_wptr <= r_wptr + 1'b1;
      if (w_s_hs) r_rptr <= r_rptr + 1'b1;
      if (w_r_hs && !w_s_hs)
        r_count <= r_count + 1'b1;
      else if (!w_r_hs && w_s_hs)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (w_r_hs) r_mem[r_wptr] <= m_axi_rdata[23:0];
  end

  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'h2;
  assign m_axi_arburst = 2'h1;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'h2;
  assign m_axi_arprot  = 3'h0;
  assign m_axi_arqos   = 4'h0;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_out;

  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tdata  = w_tvalid ? r_mem[r_rptr] : '0;
  assign m_axis_tuser  = w_tvalid & (r_x == '0) & (r_y == '0);
  assign m_axis_tlast  = w_tvalid & (r_x == 16'(FRAME_WIDTH - 1));

  assign frame_busy  = (r_state != S_IDLE);
  assign frame_done  = r_done;
  assign frame_error = r_err;

endmodule

// File: tb/tb_axi_frame_reader.sv
// Bench for axi_frame_reader: 8x4 frame, 4-beat bursts, 8-entry FIFO.
// Memory slave plus stream sink with AR and pixel scoreboards.
module tb_axi_frame_reader;

  localparam int W = 8;
  localparam int H = 4;
  localparam int BL = 4;
  localparam int FD = 8;
  localparam int NPIX = W * H;
  localparam int NB = NPIX / BL;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, rresp;
  logic        arlock, arvalid, arready;
  logic [3:0]  arcache, arqos;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;
  logic [23:0] tdata;
  logic        tvalid, tready, tuser, tlast;
  logic        frame_start = 1'b0;
  logic        busy, done, ferr;

  axi_frame_reader #(
    .C_M_AXI_TARGET_SLAVE_BASE_ADDR(BASE),
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H),
    .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tuser(tuser),
    .m_axis_tlast(tlast),
    .frame_start(frame_start), .frame_busy(busy),
    .frame_done(done), .frame_error(ferr)
  );

  int checks = 0;
  int errors = 0;

  logic [25:0] exp_px[$];
  logic [31:0] exp_ar[$];
  logic [31:0] ar_q[$];

  int pix_cnt, ar_cnt, done_cnt, rbeat_cnt;
  int tmode = 0;
  bit rnd = 0;
  bit err_en = 0;
  int err_word = 0;

  // slave + sink: drive at negedge, sample 1 ns before posedge
  initial begin : bus
    int beat, word, occ;
    bit hs_ar, hs_r, hs_s, s_done;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    logic [25:0] s_px, e;
    beat = 0;
    hs_ar = 0; hs_r = 0; hs_s = 0; s_done = 0;
    arready = 0; rvalid = 0; rdata = '0;
    rresp = '0; rlast = 0; tready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_q.delete();
        beat = 0;
        hs_ar = 0; hs_r = 0; hs_s = 0; s_done = 0;
        arready = 0; rvalid = 0; rlast = 0;
        rresp = '0; tready = 0;
        continue;
      end
      if (hs_s) begin
        pix_cnt++;
        checks++;
        if (exp_px.size() == 0) begin
          errors++;
          $display("FAIL pixel_extra got %h exp none", s_px);
        end else begin
          e = exp_px.pop_front();
          if (s_px !== e) begin
            errors++;
            $display("FAIL pixel got %h exp %h", s_px, e);
          end
        end
      end
      if (hs_r) begin
        rvalid = 0;
        rbeat_cnt++;
        occ = rbeat_cnt - pix_cnt;
        checks++;
        if (occ > FD) begin
          errors++;
          $display("FAIL fifo_occ got %0d exp <=%0d", occ, FD);
        end
        if (beat == BL - 1) begin
          beat = 0;
          void'(ar_q.pop_front());
        end else begin
          beat++;
        end
      end
      if (hs_ar) begin
        ar_cnt++;
        checks++;
        if (ar_q.size() != 0) begin
          errors++;
          $display("FAIL outstanding got %0d exp 0", ar_q.size());
        end
        ar_q.push_back(s_addr);
        checks++;
        if (exp_ar.size() == 0) begin
          errors++;
          $display("FAIL ar_extra got %h exp none", s_addr);
        end else begin
          e = 26'(0);
          s_px = 26'(0);
          if (s_addr !== exp_ar[0] || s_len !== 8'(BL - 1)) begin
            errors++;
            $display("FAIL araddr got %h/%0d exp %h/%0d",
                     s_addr, s_len, exp_ar[0], BL - 1);
          end
          void'(exp_ar.pop_front());
        end
      end
      if (s_done) done_cnt++;
      arready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (!rvalid && ar_q.size() != 0 &&
          (!rnd || $urandom_range(0, 2) != 0)) begin
        word = int'((ar_q[0] - BASE) >> 2) + beat;
        rvalid = 1;
        rdata = {8'hA5, 24'(word)};
        rresp = (err_en && word == err_word) ? 2'b10 : 2'b00;
        rlast = (beat == BL - 1);
      end
      tready = (tmode == 0) ? 1'b1 :
               (tmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      #4;
      hs_ar = arvalid && arready;
      s_addr = araddr;
      s_len = arlen;
      hs_r = rvalid && rready;
      hs_s = tvalid && tready;
      s_px = {tuser, tlast, tdata};
      s_done = done;
    end
  end

  task automatic start_frame();
    @(posedge clk);
    pix_cnt = 0; ar_cnt = 0;
    done_cnt = 0; rbeat_cnt = 0;
    for (int n = 0; n < NPIX; n++)
      exp_px.push_back({n == 0, (n % W) == W - 1, 24'(n)});
    for (int k = 0; k < NB; k++)
      exp_ar.push_back(BASE + 32'(k * BL * 4));
    @(negedge clk);
    frame_start = 1'b1;
    repeat (2) @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({arvalid, rready, tvalid, tuser, tlast,
         busy, done, ferr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 00000000",
               {arvalid, rready, tvalid, tuser, tlast, busy, done, ferr});
    end
    checks++;
    if (araddr !== 32'h0 || tdata !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h exp 0/0", araddr, tdata);
    end
    checks++;
    if ({arlen, arsize, arburst, arlock, arcache, arprot, arqos} !==
        {8'd3, 3'd2, 2'd1, 1'b0, 4'h2, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_const got %h/%h/%h/%h/%h/%h/%h exp 3/2/1/0/2/0/0",
               arlen, arsize, arburst, arlock, arcache, arprot, arqos);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    tmode = 0; rnd = 0; err_en = 0;
    start_frame();
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done got timeout exp pulse");
    end
    checks++;
    if (pix_cnt != NPIX || ar_cnt != NB || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_counts got %0d/%0d/%0d exp %0d/%0d/1",
               pix_cnt, ar_cnt, done_cnt, NPIX, NB);
    end
    checks++;
    if (busy !== 1'b0 || ferr !== 1'b0 || exp_px.size() != 0) begin
      errors++;
      $display("FAIL basic_end got busy=%b err=%b left=%0d exp 0/0/0",
               busy, ferr, exp_px.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    tmode = 1; rnd = 1; err_en = 0;
    start_frame();
    wait_done(5000, ok);
    checks++;
    if (!ok || pix_cnt != NPIX || ar_cnt != NB || done_cnt != 1) begin
      errors++;
      $display("FAIL random got ok=%0d %0d/%0d/%0d exp 1 %0d/%0d/1",
               ok, pix_cnt, ar_cnt, done_cnt, NPIX, NB);
    end
    checks++;
    if (busy !== 1'b0 || exp_px.size() != 0 || exp_ar.size() != 0) begin
      errors++;
      $display("FAIL random_end got busy=%b left=%0d/%0d exp 0/0/0",
               busy, exp_px.size(), exp_ar.size());
    end
    tmode = 0; rnd = 0;
  endtask

  task automatic test_backpressure();
    bit ok;
    tmode = 2; rnd = 0; err_en = 0;
    start_frame();
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (ar_cnt != 2 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got ar=%0d arvalid=%b exp 2/0", ar_cnt, arvalid);
    end
    checks++;
    if (pix_cnt != 0 || tvalid !== 1'b1 || tuser !== 1'b1) begin
      errors++;
      $display("FAIL bp_head got pix=%0d tv=%b tu=%b exp 0/1/1",
               pix_cnt, tvalid, tuser);
    end
    tmode = 0;
    wait_done(2000, ok);
    checks++;
    if (!ok || pix_cnt != NPIX || ar_cnt != NB || exp_px.size() != 0) begin
      errors++;
      $display("FAIL bp_resume got ok=%0d pix=%0d ar=%0d exp 1/%0d/%0d",
               ok, pix_cnt, ar_cnt, NPIX, NB);
    end
  endtask

  task automatic test_error();
    bit ok;
    tmode = 0; rnd = 0;
    err_en = 1; err_word = 5;
    start_frame();
    wait_done(2000, ok);
    checks++;
    if (!ok || ferr !== 1'b1 || pix_cnt != NPIX) begin
      errors++;
      $display("FAIL err_frame got ok=%0d err=%b pix=%0d exp 1/1/%0d",
               ok, ferr, pix_cnt, NPIX);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (ferr !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b exp 1", ferr);
    end
    err_en = 0;
    start_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ferr !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_clear got err=%b busy=%b exp 0/1", ferr, busy);
    end
    wait_done(2000, ok);
    checks++;
    if (!ok || ferr !== 1'b0 || pix_cnt != NPIX) begin
      errors++;
      $display("FAIL err_clean got ok=%0d err=%b pix=%0d exp 1/0/%0d",
               ok, ferr, pix_cnt, NPIX);
    end
  endtask

  task automatic test_restart_ignored();
    bit ok;
    bit hit;
    tmode = 1; rnd = 1; err_en = 0;
    start_frame();
    hit = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (pix_cnt >= 3) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL restart_wait got pix=%0d exp >=3", pix_cnt);
    end
    @(negedge clk);
    frame_start = 1'b1;
    repeat (3) @(negedge clk);
    frame_start = 1'b0;
    wait_done(5000, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (!ok || pix_cnt != NPIX || done_cnt != 1 || ar_cnt != NB) begin
      errors++;
      $display("FAIL restart got ok=%0d %0d/%0d/%0d exp 1 %0d/1/%0d",
               ok, pix_cnt, done_cnt, ar_cnt, NPIX, NB);
    end
    checks++;
    if (busy !== 1'b0 || exp_px.size() != 0) begin
      errors++;
      $display("FAIL restart_idle got busy=%b left=%0d exp 0/0",
               busy, exp_px.size());
    end
    tmode = 0; rnd = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    tmode = 0; rnd = 0; err_en = 0;
    start_frame();
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (pix_cnt >= 10) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid_wait got pix=%0d exp >=10", pix_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, tvalid, tuser, tlast, busy, done, ferr} !== 8'h00 ||
        araddr !== 32'h0 || tdata !== 24'h0) begin
      errors++;
      $display("FAIL rstmid_out got %b %h %h exp 00000000 0 0",
               {arvalid, rready, tvalid, tuser, tlast, busy, done, ferr},
               araddr, tdata);
    end
    exp_px.delete();
    exp_ar.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_frame();
    wait_done(2000, ok);
    checks++;
    if (!ok || pix_cnt != NPIX || ar_cnt != NB || exp_ar.size() != 0) begin
      errors++;
      $display("FAIL rstmid_new got ok=%0d pix=%0d ar=%0d exp 1/%0d/%0d",
               ok, pix_cnt, ar_cnt, NPIX, NB);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_error();
    test_restart_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
